// File: rtl/median_window_3x3.sv
// median_window_3x3: 3x3 neighbourhood generator for a raster pixel stream.
// Pops pixels from a FWFT FIFO, keeps the two previous lines in line
// buffers and presents a full 3x3 window for every interior pixel on a
// valid/ready output register.
// Optional build macro: MEDIAN_WINDOW_MARKERS_EN adds win_sof / win_eol.
module median_window_3x3 #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_dout,
  output logic               fifo_rd_en,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*WIDTH-1:0] win_data
`ifdef MEDIAN_WINDOW_MARKERS_EN
  ,
  output logic               win_sof,
  output logic               win_eol
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             emit;

  // lb0 holds line row-1, lb1 holds line row-2.
  logic [WIDTH-1:0] lb0 [IMG_W];
  logic [WIDTH-1:0] lb1 [IMG_W];

  // win_q[r][c]: r=0 top (oldest line), c=0 left (oldest column).
  logic [WIDTH-1:0] win_q    [3][3];
  logic [WIDTH-1:0] win_next [3][3];
  logic [9*WIDTH-1:0] win_flat;

  // Pop whenever a pixel is available and the output register can take a
  // window; held off during reset so no pixel is lost while counters clear.
  assign fifo_rd_en = rst_n && !fifo_empty && (!win_valid || win_ready);
  assign accept     = fifo_rd_en;
  assign emit       = accept && (row >= ROW_TWO) && (col >= COL_TWO);

  // Raster position of the pixel at the FIFO head.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers: shift the column of the two previous lines down by one.
  // NOTE: the buffers are deliberately not reset; rows 0 and 1 rewrite them
  // before any window can read them, and a reset would cost a full clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= fifo_dout;
    end
  end

  // Next window: shift columns left and append {lb1, lb0, pix} on the right.
  // NOTE: every output is assigned a default first so no latch is inferred.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        win_next[r][c] = win_q[r][c+1];
      end
    end
    win_next[0][2] = lb1[col];
    win_next[1][2] = lb0[col];
    win_next[2][2] = fifo_dout;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_flat[WIDTH*(3*r+c) +: WIDTH] = win_next[r][c];
      end
    end
  end

  // Window shift register advances on every accept, emitting or not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win_q <= win_next;
    end
  end

  // Output register: load on an emitting accept, clear valid on a bare
  // handshake, hold everything otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_data  <= '0;
`ifdef MEDIAN_WINDOW_MARKERS_EN
      win_sof   <= 1'b0;
      win_eol   <= 1'b0;
`endif
    end else if (emit) begin
      win_valid <= 1'b1;
      win_data  <= win_flat;
`ifdef MEDIAN_WINDOW_MARKERS_EN
      win_sof   <= (row == ROW_TWO) && (col == COL_TWO);
      win_eol   <= (col == COL_LAST);
`endif
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_window_3x3.sv
// Directed bench for median_window_3x3 with an 8x6 image, pixel = row*16+col.
// Honors MEDIAN_WINDOW_MARKERS_EN when defined for the build.
module tb_median_window_3x3;

  localparam int WIDTH = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int FRAME = IMG_W * IMG_H;
  localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               fifo_empty;
  logic [WIDTH-1:0]   fifo_dout;
  logic               fifo_rd_en;
  logic               win_valid;
  logic               win_ready;
  logic [9*WIDTH-1:0] win_data;
`ifdef MEDIAN_WINDOW_MARKERS_EN
  logic               win_sof;
  logic               win_eol;
`endif

  int n_vec = 0;
  int n_err = 0;
  int src_idx, src_len, win_k, n_win;
  logic [9*WIDTH-1:0] first_win, last_win, f2_first_win;

  median_window_3x3 #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data)
`ifdef MEDIAN_WINDOW_MARKERS_EN
    ,
    .win_sof    (win_sof),
    .win_eol    (win_eol)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pixel at stream position p (frames repeat back to back).
  function automatic logic [7:0] pix_at(input int p);
    int q;
    q = p % FRAME;
    return 8'(((q / IMG_W) * 16) + (q % IMG_W));
  endfunction

  // k-th window of a frame: center at (1 + k/6, 1 + k%6).
  function automatic logic [71:0] exp_win(input int k);
    logic [71:0] w;
    int cr, cc;
    w  = '0;
    cr = 1 + k / (IMG_W - 2);
    cc = 1 + k % (IMG_W - 2);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = 8'(((cr - 1 + r) * 16) + (cc - 1 + c));
    return w;
  endfunction

  // Feed n_pix pixels from frame position 0 and consume windows until the
  // stream is drained. gaps: random empty cycles. bp_at: window index held
  // for 5 cycles with win_ready low (-1 = none).
  task automatic run_stream(input int n_pix, input bit gaps, input int bp_at);
    int  cycles;
    int  bp_left;
    bit  pop;
    cycles  = 0;
    bp_left = 5;
    src_idx = 0;
    src_len = n_pix;
    n_win   = 0;
    win_k   = 0;
    forever begin
      @(negedge clk);
      if (src_idx >= src_len && !win_valid) break;
      if (cycles >= 3000) begin
        n_vec++;
        n_err++;
        $error("FAIL timeout: observed %0d cycles expected drain", cycles);
        break;
      end
      cycles++;
      fifo_empty = (src_idx >= src_len) || (gaps && $urandom_range(0, 2) == 0);
      fifo_dout  = pix_at(src_idx);
      win_ready  = !(bp_at >= 0 && win_valid && win_k == bp_at && bp_left > 0);
      #1;
      if (fifo_empty) check("rd_en_while_empty", 72'(fifo_rd_en), 72'(0));
      if (!win_ready) begin
        bp_left--;
        check("bp_valid",  72'(win_valid),        72'(1));
        check("bp_rd_en",  72'(fifo_rd_en),       72'(0));
        check("bp_center", 72'(win_data[39:32]),  72'(8'h13));
        check("bp_hold",   win_data,              exp_win(bp_at));
      end
      if (win_valid && win_ready) begin
        check("win_data", win_data, exp_win(win_k));
`ifdef MEDIAN_WINDOW_MARKERS_EN
        check("win_sof", 72'(win_sof), 72'(win_k == 0));
        check("win_eol", 72'(win_eol), 72'((win_k % (IMG_W - 2)) == (IMG_W - 3)));
`endif
        if (n_win == 0)    first_win    = win_data;
        if (n_win == NWIN) f2_first_win = win_data;
        last_win = win_data;
        n_win++;
        win_k = (win_k == NWIN - 1) ? 0 : win_k + 1;
      end
      pop = fifo_rd_en;
      @(posedge clk);
      if (pop) src_idx++;
    end
    fifo_empty = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    fifo_empty = 1'b0;
    fifo_dout  = 8'h55;
    win_ready  = 1'b1;

    // Reset state: no pop during reset, cleared outputs afterwards.
    repeat (3) @(negedge clk);
    #1;
    check("rd_en_in_reset", 72'(fifo_rd_en), 72'(0));
    fifo_empty = 1'b1;
    rst_n      = 1'b1;
    @(negedge clk);
    #1;
    check("reset_valid", 72'(win_valid), 72'(0));
    check("reset_data",  win_data,       72'(0));
`ifdef MEDIAN_WINDOW_MARKERS_EN
    check("reset_sof", 72'(win_sof), 72'(0));
    check("reset_eol", 72'(win_eol), 72'(0));
`endif

    // Basic frame.
    run_stream(FRAME, 1'b0, -1);
    check("basic_count",  72'(n_win), 72'(NWIN));
    check("basic_first",  first_win,  72'h22_21_20_12_11_10_02_01_00);
    check("basic_last_c", 72'(last_win[39:32]), 72'(8'h46));

    // Backpressure at the third window.
    run_stream(FRAME, 1'b0, 2);
    check("bp_count", 72'(n_win), 72'(NWIN));

    // Random FIFO gaps.
    run_stream(FRAME, 1'b1, -1);
    check("gaps_count", 72'(n_win), 72'(NWIN));
    check("gaps_first", first_win,  72'h22_21_20_12_11_10_02_01_00);

    // Two frames back to back.
    run_stream(2 * FRAME, 1'b0, -1);
    check("b2b_count",  72'(n_win),   72'(2 * NWIN));
    check("b2b_first2", f2_first_win, 72'h22_21_20_12_11_10_02_01_00);

    // Reset mid-frame after 20 pixels, with a window pending.
    run_stream(20, 1'b0, -1);
    check("partial_count", 72'(n_win), 72'(2));
    @(negedge clk);
    fifo_empty = 1'b0;
    fifo_dout  = pix_at(20);
    win_ready  = 1'b0;
    @(negedge clk);
    #1;
    check("pre_reset_valid", 72'(win_valid), 72'(1));
    check("pre_reset_data",  win_data,       exp_win(2));
    rst_n = 1'b0;
    #1;
    check("rd_en_mid_reset", 72'(fifo_rd_en), 72'(0));
    @(negedge clk);
    rst_n      = 1'b1;
    fifo_empty = 1'b1;
    win_ready  = 1'b1;
    #1;
    check("post_reset_valid", 72'(win_valid), 72'(0));
    check("post_reset_data",  win_data,       72'(0));
    run_stream(FRAME, 1'b0, -1);
    check("refeed_count", 72'(n_win), 72'(NWIN));
    check("refeed_first", first_win,  72'h22_21_20_12_11_10_02_01_00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
